decode_execute_skid_reg: RTL and testbench
==========================================

// Module: decode_execute_skid_reg
// PURPOSE
//  Parametrised decode->execute pipeline register with valid/ready handshake and a
//  2-entry skid buffer, so back-pressure from execute never combinationally reaches decode.
//  Sits between the decode stage (regfile read, extend, control unit) and the execute stage.
//  Empty slots drive an all-zero payload (NOP bubble). Flush squashes all held work.
// PARAMETERS
//  XLEN       32  data/PC/immediate width
//  RA_W       5   register-address width (rs1/rs2/rd)
//  CTRL_W     10  packed control bundle {RegWrite,ResultSrc[1:0],MemWrite,Jump,Branch,ALUControl[2:0],ALUSrc}
//  LOAD_BIT   7   index in ctrl bundle that is 1 for loads (ResultSrc[0]); used only with LOAD_USE_STALL_EN
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       squash held and incoming entries (branch/jump taken)
//  d_valid    in   1       decode offers a beat
//  d_ready    out  1       block can accept a beat
//  d_ctrl     in   CTRL_W  control bundle
//  d_rd1      in   XLEN    rs1 read data
//  d_rd2      in   XLEN    rs2 read data
//  d_pc       in   XLEN    PC of instruction
//  d_pcplus4  in   XLEN    PC+4
//  d_imm      in   XLEN    extended immediate
//  d_rs1      in   RA_W    rs1 address
//  d_rs2      in   RA_W    rs2 address
//  d_rd       in   RA_W    rd address
//  e_valid    out  1       execute-side beat valid
//  e_ready    in   1       execute consumes beat
//  e_ctrl, e_rd1, e_rd2, e_pc, e_pcplus4, e_imm, e_rs1, e_rs2, e_rd  out  widths as d_*  registered payload
//  hazard_stall out 1      load-use stall active (tied 0 without LOAD_USE_STALL_EN)
// BEHAVIOUR
//  - One payload register MAIN (drives e_*) plus one SKID register; every output is registered except d_ready/hazard_stall.
//  - States: EMPTY (e_valid=0), FULL (MAIN valid), SKID (MAIN+SKID valid).
//  - Handshake completes when valid&ready both high at posedge. d_ready = (state!=SKID) & ~hazard_stall; it does not depend on e_ready.
//  - acc = d_valid & d_ready & ~flush; pop = e_valid & e_ready.
//  - EMPTY: acc -> FULL, MAIN<=d_*. Latency: beat accepted in cycle N is on e_* with e_valid=1 in cycle N+1.
//  - FULL : pop&acc -> FULL (MAIN<=d_*); pop&~acc -> EMPTY; ~pop&acc -> SKID (SKID<=d_*); else hold.
//  - SKID : pop -> FULL (MAIN<=SKID); d_ready=0 so no accept; else hold.
//  - flush: next state EMPTY regardless of state/pop/acc; incoming beat in the flush cycle is dropped; MAIN and SKID cleared.
//  - Whenever next state is EMPTY, MAIN is cleared to 0 so e_* form a NOP (RegWrite=MemWrite=Jump=Branch=0).
//  - Payload order preserved (FIFO); no beat duplicated or lost except by flush.
//  - Reset (any time, incl. mid-transfer): state EMPTY, e_valid=0, all e_* = 0, SKID = 0, d_ready=1, hazard_stall=0 on deassert. Reset dominates flush.
//  - No arithmetic; all fields pass through unmodified at their declared widths.
// CONFIGURATION
//  LOAD_USE_STALL_EN defined: hazard_stall = e_valid & e_ctrl[LOAD_BIT] & (e_rd!=0) & d_valid &
//    ((d_rs1==e_rd)|(d_rs2==e_rd)); when high d_ready=0 and decode must hold its beat. Checked against
//    MAIN only (SKID entry is younger than MAIN and is checked once it reaches MAIN).
//  LOAD_USE_STALL_EN undefined: hazard_stall tied 0, no comparators; external hazard unit owns stalls.
// TESTING
//  1 reset high mid-SKID then low -> e_valid=0, e_ctrl=0, e_pc=0, d_ready=1 next cycle.
//  2 e_ready=1, d_valid=1 every cycle, pc=0x0,0x4,0x8 -> e_pc=0x0,0x4,0x8 one cycle later, d_ready always 1.
//  3 e_ready=0, send pc=0x10,0x14 -> state SKID, d_ready=0; raise e_ready -> e_pc 0x10 then 0x14, no loss.
//  4 FULL with pc=0x20, flush=1 with d_valid pc=0x24 -> next cycle e_valid=0, e_ctrl=0; 0x24 never appears.
//  5 (LOAD_USE_STALL_EN) MAIN load rd=5, d_rs2=5, e_ready=0 -> hazard_stall=1, d_ready=0; pop -> stall drops.
//  6 (LOAD_USE_STALL_EN) MAIN load rd=0, d_rs1=0 -> hazard_stall=0; undefined build -> hazard_stall=0 always.

Source files
------------

// File: rtl/decode_execute_skid_reg.sv
// decode_execute_skid_reg
//   Decode->execute pipeline register with a valid/ready handshake and a
//   2-entry skid (MAIN drives e_*, SKID catches one beat while execute stalls).
//   d_ready depends only on local state, so execute back-pressure never reaches
//   decode combinationally. Empty slots present an all-zero NOP payload.
//   Optional build macro: LOAD_USE_STALL_EN adds a load-use hazard stall
//   checked against the MAIN entry; without it hazard_stall is tied low.
module decode_execute_skid_reg #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int CTRL_W   = 10,
  parameter int LOAD_BIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [XLEN-1:0]   d_rd1,
  input  logic [XLEN-1:0]   d_rd2,
  input  logic [XLEN-1:0]   d_pc,
  input  logic [XLEN-1:0]   d_pcplus4,
  input  logic [XLEN-1:0]   d_imm,
  input  logic [RA_W-1:0]   d_rs1,
  input  logic [RA_W-1:0]   d_rs2,
  input  logic [RA_W-1:0]   d_rd,
  output logic              e_valid,
  input  logic              e_ready,
  output logic [CTRL_W-1:0] e_ctrl,
  output logic [XLEN-1:0]   e_rd1,
  output logic [XLEN-1:0]   e_rd2,
  output logic [XLEN-1:0]   e_pc,
  output logic [XLEN-1:0]   e_pcplus4,
  output logic [XLEN-1:0]   e_imm,
  output logic [RA_W-1:0]   e_rs1,
  output logic [RA_W-1:0]   e_rs2,
  output logic [RA_W-1:0]   e_rd,
  output logic              hazard_stall
);

  localparam int PW = CTRL_W + 5 * XLEN + 3 * RA_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  if (LOAD_BIT >= CTRL_W) begin : g_load_bit_range
    $error("LOAD_BIT must index inside the control bundle");
  end

  logic [1:0]    state_q, state_d;
  logic          e_valid_q, e_valid_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] d_payload;
  logic          acc, pop;

  assign d_payload = {d_ctrl, d_rd1, d_rd2, d_pc, d_pcplus4, d_imm, d_rs1, d_rs2, d_rd};
  assign {e_ctrl, e_rd1, e_rd2, e_pc, e_pcplus4, e_imm, e_rs1, e_rs2, e_rd} = main_q;
  assign e_valid = e_valid_q;

`ifdef LOAD_USE_STALL_EN
  // Load-use stall: the load sitting in MAIN writes a register decode wants to read.
  always_comb begin
    hazard_stall = e_valid_q & e_ctrl[LOAD_BIT] & (e_rd != '0) & d_valid &
                   ((d_rs1 == e_rd) | (d_rs2 == e_rd));
  end
`else
  assign hazard_stall = 1'b0;
`endif

  assign d_ready = (state_q != ST_SKID) & ~hazard_stall;
  assign acc     = d_valid & d_ready & ~flush;
  assign pop     = e_valid_q & e_ready;

  // Next-state and payload steering for the MAIN/SKID pair.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_FULL;
          main_d  = d_payload;
        end
      end
      ST_FULL: begin
        if (pop && acc) begin
          main_d = d_payload;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end else if (acc) begin
          state_d = ST_SKID;
          skid_d  = d_payload;
        end
      end
      ST_SKID: begin
        if (pop) begin
          state_d = ST_FULL;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        skid_d  = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      skid_d  = '0;
    end
    // An empty MAIN must read as a NOP bubble downstream.
    if (state_d == ST_EMPTY) begin
      main_d = '0;
    end
    e_valid_d = (state_d != ST_EMPTY);
  end

  // State, valid and payload registers; reset returns to an empty NOP slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      e_valid_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      e_valid_q <= e_valid_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
    end
  end

endmodule

// File: tb/tb_decode_execute_skid_reg.sv
// tb_decode_execute_skid_reg
//   Directed and random stimulus against a queue-based reference model of a
//   2-deep FIFO stage. Honours LOAD_USE_STALL_EN when defined.
module tb_decode_execute_skid_reg;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } beat_t;

`ifdef LOAD_USE_STALL_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, d_valid, e_ready;
  beat_t din;
  logic d_ready, e_valid, hazard_stall;
  logic [9:0]  e_ctrl;
  logic [31:0] e_rd1, e_rd2, e_pc, e_pcplus4, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  beat_t obs;

  int n_assert = 0;
  int n_fail   = 0;
  beat_t q[$];
  logic obs_haz, obs_rdy;

  always #5 clk = ~clk;

  assign obs = {e_ctrl, e_rd1, e_rd2, e_pc, e_pcplus4, e_imm, e_rs1, e_rs2, e_rd};

  decode_execute_skid_reg #(
    .XLEN(32), .RA_W(5), .CTRL_W(10), .LOAD_BIT(7)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_ctrl(din.ctrl), .d_rd1(din.rd1), .d_rd2(din.rd2), .d_pc(din.pc),
    .d_pcplus4(din.pcplus4), .d_imm(din.imm),
    .d_rs1(din.rs1), .d_rs2(din.rs2), .d_rd(din.rd),
    .e_valid(e_valid), .e_ready(e_ready),
    .e_ctrl(e_ctrl), .e_rd1(e_rd1), .e_rd2(e_rd2), .e_pc(e_pc),
    .e_pcplus4(e_pcplus4), .e_imm(e_imm),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .hazard_stall(hazard_stall)
  );

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] pc, input logic [9:0] ctrl,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    beat_t b;
    b.ctrl = ctrl; b.rd1 = $urandom; b.rd2 = $urandom; b.pc = pc;
    b.pcplus4 = pc + 32'd4; b.imm = $urandom;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd;
    return b;
  endfunction

  function automatic beat_t rb();
    beat_t b;
    b = mk($urandom, 10'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    return b;
  endfunction

  // Load-use rule evaluated on the oldest held beat.
  function automatic logic model_haz(input logic v, input beat_t b);
    if (!HAZ_EN || q.size() == 0 || !v) return 1'b0;
    return q[0].ctrl[7] && (q[0].rd != 5'd0) && (b.rs1 == q[0].rd || b.rs2 == q[0].rd);
  endfunction

  // One clock: drive, check against the model, then advance the model at the edge.
  task automatic cycle(input logic v, input logic er, input logic fl, input beat_t b);
    logic haz, rdy, acc, pop;
    beat_t head;
    @(negedge clk);
    d_valid = v; e_ready = er; flush = fl; din = b;
    #1;
    haz  = model_haz(v, b);
    rdy  = (q.size() < 2) && !haz;
    head = (q.size() > 0) ? q[0] : '0;
    chk("e_valid", e_valid, q.size() > 0);
    chk("payload", obs, head);
    chk("d_ready", d_ready, rdy);
    chk("hazard", hazard_stall, haz);
    obs_haz = hazard_stall;
    obs_rdy = d_ready;
    acc = v && rdy && !fl;
    pop = (q.size() > 0) && er;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; d_valid = 1'b0; e_ready = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_e_valid", e_valid, 1'b0);
    chk("rst_payload", obs, '0);
    reset = 1'b0;
    #1;
    chk("rst_d_ready", d_ready, 1'b1);
    chk("rst_hazard", hazard_stall, 1'b0);

    // Streaming with execute always ready.
    cycle(1, 1, 0, mk(32'h0, 10'h200, 5'd1, 5'd2, 5'd3)); #1 chk("t2_pc0", e_pc, 32'h0);
    chk("t2_rdy0", obs_rdy, 1'b1);
    cycle(1, 1, 0, mk(32'h4, 10'h200, 5'd1, 5'd2, 5'd3)); #1 chk("t2_pc4", e_pc, 32'h4);
    chk("t2_rdy4", obs_rdy, 1'b1);
    cycle(1, 1, 0, mk(32'h8, 10'h200, 5'd1, 5'd2, 5'd3)); #1 chk("t2_pc8", e_pc, 32'h8);
    chk("t2_rdy8", obs_rdy, 1'b1);
    cycle(0, 1, 0, '0); #1 chk("t2_drain", e_valid, 1'b0);

    // Back-pressure fills the skid entry, then drains in order.
    cycle(1, 0, 0, mk(32'h10, 10'h200, 5'd1, 5'd2, 5'd3));
    cycle(1, 0, 0, mk(32'h14, 10'h200, 5'd1, 5'd2, 5'd3));
    cycle(1, 0, 0, mk(32'h18, 10'h200, 5'd1, 5'd2, 5'd3));
    chk("t3_skid_rdy", obs_rdy, 1'b0);
    #1 chk("t3_pc10", e_pc, 32'h10);
    cycle(0, 1, 0, '0); #1 chk("t3_pc14", e_pc, 32'h14);
    chk("t3_valid", e_valid, 1'b1);
    cycle(0, 1, 0, '0); #1 chk("t3_empty", e_valid, 1'b0);

    // Flush drops held and incoming beats.
    cycle(1, 0, 0, mk(32'h20, 10'h3ff, 5'd1, 5'd2, 5'd3));
    cycle(1, 0, 1, mk(32'h24, 10'h3ff, 5'd1, 5'd2, 5'd3));
    #1 chk("t4_valid", e_valid, 1'b0);
    chk("t4_ctrl", e_ctrl, 10'h0);
    cycle(0, 1, 0, '0); #1 chk("t4_no24", e_pc, 32'h0);

    // Load-use on rd=5 via rs2.
    cycle(1, 0, 0, mk(32'h30, 10'h080, 5'd0, 5'd0, 5'd5));
    cycle(1, 0, 0, mk(32'h34, 10'h200, 5'd7, 5'd5, 5'd6));
    chk("t5_haz", obs_haz, HAZ_EN);
    chk("t5_rdy", obs_rdy, !HAZ_EN);
    cycle(1, 1, 0, mk(32'h34, 10'h200, 5'd7, 5'd5, 5'd6));
    cycle(1, 1, 0, mk(32'h34, 10'h200, 5'd7, 5'd5, 5'd6));
    chk("t5_drop", obs_haz, 1'b0);
    repeat (3) cycle(0, 1, 0, '0);

    // Load to x0 never stalls.
    cycle(1, 0, 0, mk(32'h40, 10'h080, 5'd0, 5'd0, 5'd0));
    cycle(1, 0, 0, mk(32'h44, 10'h200, 5'd0, 5'd0, 5'd1));
    chk("t6_haz", obs_haz, 1'b0);
    chk("t6_rdy", obs_rdy, 1'b1);
    repeat (3) cycle(0, 1, 0, '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), rb());
    end

    // Asynchronous reset while both entries are occupied.
    cycle(1, 0, 0, mk(32'h50, 10'h3ff, 5'd1, 5'd2, 5'd3));
    cycle(1, 0, 0, mk(32'h54, 10'h3ff, 5'd1, 5'd2, 5'd3));
    cycle(1, 0, 0, mk(32'h58, 10'h3ff, 5'd1, 5'd2, 5'd3));
    #2 reset = 1'b1;
    #1;
    chk("t1_valid", e_valid, 1'b0);
    chk("t1_ctrl", e_ctrl, 10'h0);
    chk("t1_pc", e_pc, 32'h0);
    q.delete();
    @(negedge clk);
    reset = 1'b0; d_valid = 1'b0;
    #1;
    chk("t1_rdy", d_ready, 1'b1);
    chk("t1_haz", hazard_stall, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, rb());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
